// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: width function, field offsets
// and a packed flit struct for the splitter and assembler.
package noc_pkg;

    localparam int IDX_W  = 2;
    localparam int DATA_W = 8;
    localparam int DEF_NW = 3;
    localparam int DEF_PW = 5;

    // Flit layout, MSB first:
    // {vld, dest[NW], data[8], pid[PW], src[NW], idx[2]}
    function automatic int flit_width(input int nw, input int pw);
        return 1 + 2 * nw + DATA_W + pw + IDX_W;
    endfunction

    localparam int OFF_IDX = 0;
    localparam int OFF_SRC = IDX_W;

    function automatic int off_pid(input int nw);
        return IDX_W + nw;
    endfunction

    function automatic int off_data(input int nw, input int pw);
        return IDX_W + nw + pw;
    endfunction

    function automatic int off_dest(input int nw, input int pw);
        return IDX_W + nw + pw + DATA_W;
    endfunction

    function automatic int off_vld(input int nw, input int pw);
        return IDX_W + 2 * nw + pw + DATA_W;
    endfunction

    // Flit view for the default 8-node, 5-bit packet id build.
    typedef struct packed {
        logic              vld;
        logic [DEF_NW-1:0] dest;
        logic [DATA_W-1:0] data;
        logic [DEF_PW-1:0] pid;
        logic [DEF_NW-1:0] src;
        logic [IDX_W-1:0]  idx;
    } flit_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO, power-of-two depth.
// Ports: clk, rst (sync, high), push/din, pop/dout, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CAP);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    // Drive zero while empty so the word bus is clean after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flit_assembler.sv
// Reassembles four byte flits per source into 32-bit words.
// Ports: clk, rst, ce, flit_in/flit_valid in; out_* handshake,
// err_count and drop_count (saturating) out.
module flit_assembler
    import noc_pkg::*;
#(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int OUT_DEPTH       = 4,
    localparam int NW = $clog2(NODE_COUNT),
    localparam int PW = PACKET_ID_WIDTH,
    localparam int FW = flit_width(NW, PW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [FW-1:0] flit_in,
    input  logic          flit_valid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [NW-1:0] out_src,
    output logic [PW-1:0] out_pid,
    output logic [7:0]    err_count,
    output logic [7:0]    drop_count
);

    localparam int SLOTS = 1 << NW;
    localparam int OW    = NW + PW + 32;
    localparam logic [NW-1:0] MY_ID = NW'(NODE_ID);

    logic          f_vld;
    logic [NW-1:0] f_dest;
    logic [7:0]    f_data;
    logic [PW-1:0] f_pid;
    logic [NW-1:0] f_src;
    logic [1:0]    f_idx;

    assign f_vld  = flit_in[off_vld(NW, PW)];
    assign f_dest = flit_in[off_dest(NW, PW) +: NW];
    assign f_data = flit_in[off_data(NW, PW) +: 8];
    assign f_pid  = flit_in[off_pid(NW) +: PW];
    assign f_src  = flit_in[OFF_SRC +: NW];
    assign f_idx  = flit_in[OFF_IDX +: 2];

    logic [SLOTS-1:0] busy;
    logic [1:0]       exp_idx  [SLOTS];
    logic [PW-1:0]    slot_pid [SLOTS];
    logic [23:0]      partial  [SLOTS];

    logic          acc;
    logic          for_me;
    logic          seq_ok;
    logic          done;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          err_inc;
    logic          drop_inc;
    logic [OW-1:0] fifo_din;
    logic [OW-1:0] fifo_dout;

    always_comb begin
        acc    = ce && flit_valid && f_vld;
        for_me = acc && (f_dest == MY_ID);
        // Busy slots always expect idx 1..3, so idx0 never matches.
        seq_ok = busy[f_src]
              && (exp_idx[f_src] == f_idx)
              && (slot_pid[f_src] == f_pid);
        pop    = ce && out_valid && out_ready;
        done   = for_me && seq_ok && (f_idx == 2'd3);
        push   = done && (!full || pop);
        if (f_idx == 2'd0) begin
            err_inc = for_me && busy[f_src];
        end else begin
            err_inc = for_me && !seq_ok;
        end
        drop_inc = (acc && !for_me) || (done && full && !pop);
    end

    assign fifo_din = {f_src, f_pid, partial[f_src], f_data};

    sync_fifo #(
        .WIDTH (OW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign {out_src, out_pid, out_data} = fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                exp_idx[i]  <= '0;
                slot_pid[i] <= '0;
                partial[i]  <= '0;
            end
        end else if (for_me) begin
            unique case (1'b1)
                (f_idx == 2'd0): begin
                    busy[f_src]     <= 1'b1;
                    exp_idx[f_src]  <= 2'd1;
                    slot_pid[f_src] <= f_pid;
                    partial[f_src]  <= {f_data, 16'h0};
                end
                (seq_ok && f_idx != 2'd3): begin
                    exp_idx[f_src] <= exp_idx[f_src] + 2'd1;
                    if (f_idx == 2'd1) begin
                        partial[f_src][15:8] <= f_data;
                    end else begin
                        partial[f_src][7:0] <= f_data;
                    end
                end
                // Completed word or sequence error: slot goes idle.
                default: busy[f_src] <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            if (drop_inc && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_flit_assembler.sv
// Bench for flit_assembler: directed scenarios with literal
// expectations plus randomized traffic against a queue model.
module tb_flit_assembler;
    import noc_pkg::*;

    localparam int NW    = 3;
    localparam int PW    = 5;
    localparam int FW    = flit_width(NW, PW);
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic [FW-1:0] flit_in = '0;
    logic          flit_valid = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [NW-1:0] out_src;
    logic [PW-1:0] out_pid;
    logic [7:0]    err_count;
    logic [7:0]    drop_count;

    always #5 clk = ~clk;

    flit_assembler #(
        .NODE_ID         (0),
        .NODE_COUNT      (8),
        .PACKET_ID_WIDTH (PW),
        .OUT_DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .flit_in    (flit_in),
        .flit_valid (flit_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_pid    (out_pid),
        .err_count  (err_count),
        .drop_count (drop_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [NW-1:0] src;
        logic [PW-1:0] pid;
        logic [31:0]   data;
    } word_t;

    word_t       mq[$];
    int          m_next[8];   // 0 = idle, else next expected idx
    int          m_pid[8];
    logic [31:0] m_word[8];
    int          m_err  = 0;
    int          m_drop = 0;
    bit          m_fresh = 1'b1;

    always @(posedge clk) begin
        flit_t f;
        word_t w;
        int    s;
        int    i;
        f = flit_in;
        if (rst) begin
            mq.delete();
            foreach (m_next[k]) m_next[k] = 0;
            m_err   = 0;
            m_drop  = 0;
            m_fresh = 1'b1;
        end else if (ce) begin
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (flit_valid && f.vld) begin
                s = int'(f.src);
                i = int'(f.idx);
                if (f.dest != 3'd0) begin
                    if (m_drop < 255) m_drop++;
                end else if (i == 0) begin
                    if (m_next[s] != 0 && m_err < 255) m_err++;
                    m_next[s] = 1;
                    m_pid[s]  = int'(f.pid);
                    m_word[s] = {f.data, 24'h0};
                end else if (m_next[s] == i && m_pid[s] == int'(f.pid)) begin
                    m_word[s][8*(3-i) +: 8] = f.data;
                    if (i == 3) begin
                        m_next[s] = 0;
                        if (mq.size() < DEPTH) begin
                            w.src  = f.src;
                            w.pid  = f.pid;
                            w.data = m_word[s];
                            mq.push_back(w);
                            m_fresh = 1'b0;
                        end else if (m_drop < 255) begin
                            m_drop++;
                        end
                    end else begin
                        m_next[s] = i + 1;
                    end
                end else begin
                    if (m_err < 255) m_err++;
                    m_next[s] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("data", out_data, mq[0].data);
            chk("src", 32'(out_src), 32'(mq[0].src));
            chk("pid", 32'(out_pid), 32'(mq[0].pid));
        end else if (m_fresh) begin
            chk("data_zero", out_data, 32'h0);
            chk("srcpid_zero", 32'({out_src, out_pid}), 32'h0);
        end
        chk("err", 32'(err_count), 32'(m_err));
        chk("drop", 32'(drop_count), 32'(m_drop));
    end

    // ---------------- stimulus ----------------
    function automatic logic [FW-1:0] mk(input logic v,
        input logic [NW-1:0] dest, input logic [NW-1:0] src,
        input logic [7:0] d, input logic [PW-1:0] pid,
        input logic [1:0] idx);
        flit_t f;
        f.vld  = v;
        f.dest = dest;
        f.data = d;
        f.pid  = pid;
        f.src  = src;
        f.idx  = idx;
        return f;
    endfunction

    task automatic send(input logic [NW-1:0] dest,
        input logic [NW-1:0] src, input logic [7:0] d,
        input logic [PW-1:0] pid, input logic [1:0] idx);
        flit_in    = mk(1'b1, dest, src, d, pid, idx);
        flit_valid = 1'b1;
        @(negedge clk);
        flit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [NW-1:0] src,
        input logic [PW-1:0] pid, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send(3'd0, src, w[8*(3-i) +: 8], pid, 2'(i));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] w1;
    logic [31:0] w3;
    int          gidx[8];
    int          gpid[8];

    initial begin
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);

        // single word, emitted one cycle after idx3
        out_ready = 1'b1;
        send_word(3'd2, 5'd5, 32'hDEADBEEF);
        chk("w0_valid", 32'(out_valid), 32'h1);
        chk("w0_data", out_data, 32'hDEADBEEF);
        chk("w0_src", 32'(out_src), 32'h2);
        chk("w0_pid", 32'(out_pid), 32'h5);
        @(negedge clk);
        chk("w0_gone", 32'(out_valid), 32'h0);

        // interleaved sources
        do_reset();
        w1 = 32'h11223344;
        w3 = 32'hAABBCCDD;
        for (int i = 0; i < 3; i++) begin
            send(3'd0, 3'd1, w1[8*(3-i) +: 8], 5'd3, 2'(i));
            send(3'd0, 3'd3, w3[8*(3-i) +: 8], 5'd7, 2'(i));
        end
        send(3'd0, 3'd1, w1[7:0], 5'd3, 2'd3);
        chk("il_w1", out_data, 32'h11223344);
        send(3'd0, 3'd3, w3[7:0], 5'd7, 2'd3);
        chk("il_w3", out_data, 32'hAABBCCDD);
        chk("il_src", 32'(out_src), 32'h3);
        chk("il_cnt", 32'({err_count, drop_count}), 32'h0);

        // skipped idx then a clean packet
        do_reset();
        send(3'd0, 3'd0, 8'h01, 5'd4, 2'd0);
        send(3'd0, 3'd0, 8'h02, 5'd4, 2'd2);
        chk("seq_err", 32'(err_count), 32'h1);
        chk("seq_nov", 32'(out_valid), 32'h0);
        send_word(3'd0, 5'd4, 32'hCAFEF00D);
        chk("seq_ok", out_data, 32'hCAFEF00D);

        // overflow: DEPTH held, one dropped, then drain in order
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            send_word(3'd4, 5'(k), 32'h10000000 + 32'(k) * 32'h111);
        end
        chk("ovf_drop", 32'(drop_count), 32'h1);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk("ovf_drain", out_data, 32'h10000000 + 32'(k) * 32'h111);
            @(negedge clk);
        end
        chk("ovf_empty", 32'(out_valid), 32'h0);

        // wrong destination, then reset mid-packet with a flit
        do_reset();
        send(3'd1, 3'd0, 8'hAA, 5'd0, 2'd0);
        chk("dest_drop", 32'(drop_count), 32'h1);
        send(3'd0, 3'd5, 8'h55, 5'd2, 2'd0);
        send(3'd0, 3'd5, 8'h66, 5'd2, 2'd1);
        rst = 1'b1;
        send(3'd0, 3'd5, 8'h77, 5'd2, 2'd2);
        rst = 1'b0;
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_cnt", 32'({err_count, drop_count}), 32'h0);
        send(3'd0, 3'd5, 8'h77, 5'd2, 2'd2);
        chk("mr_err", 32'(err_count), 32'h1);

        // clock enable low ignores flits
        do_reset();
        ce = 1'b0;
        send(3'd0, 3'd7, 8'h01, 5'd1, 2'd0);
        ce = 1'b1;
        send(3'd0, 3'd7, 8'h02, 5'd1, 2'd1);
        chk("ce_err", 32'(err_count), 32'h1);

        // saturation of both counters
        do_reset();
        repeat (300) send(3'd0, 3'd6, 8'h00, 5'd0, 2'd1);
        chk("err_sat", 32'(err_count), 32'd255);
        repeat (300) send(3'd2, 3'd6, 8'h00, 5'd0, 2'd0);
        chk("drop_sat", 32'(drop_count), 32'd255);

        // randomized traffic
        do_reset();
        foreach (gidx[k]) begin
            gidx[k] = 0;
            gpid[k] = 0;
        end
        for (int n = 0; n < 4000; n++) begin
            int s;
            int ix;
            int pd;
            logic [NW-1:0] dst;
            s  = $urandom_range(7);
            ix = gidx[s];
            if ($urandom_range(19) == 0) ix = $urandom_range(3);
            if (ix == 0) gpid[s] = $urandom_range(3);
            pd = gpid[s];
            if ($urandom_range(29) == 0) pd = $urandom_range(3);
            dst = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'd0;
            ce         = ($urandom_range(9) != 0);
            out_ready  = ($urandom_range(2) != 0);
            rst        = ($urandom_range(499) == 0);
            flit_valid = ($urandom_range(9) < 7);
            flit_in    = mk($urandom_range(9) != 0, dst, 3'(s),
                            8'($urandom), 5'(pd), 2'(ix));
            if (flit_valid) gidx[s] = (ix + 1) % 4;
            @(negedge clk);
        end
        rst        = 1'b0;
        ce         = 1'b1;
        flit_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        chk("end_drained", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
